// File: rtl/arb_pkg.sv
// Shared constants and state encoding for the 4-way round-robin arbiter.
package arb_pkg;
  localparam int N_REQ = 4;
  localparam int IDX_W = 2;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_t;
endpackage

// File: rtl/rr_pick4.sv
// Combinational rotating-priority picker: first eligible requester starting at ptr,
// optionally skipping one index (the current grantee).
module rr_pick4
  import arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  input  logic             excl_en,
  input  logic [IDX_W-1:0] excl_idx,
  output logic             any,
  output logic [IDX_W-1:0] idx
);
  logic [N_REQ-1:0]            elig;
  logic [N_REQ-1:0][IDX_W-1:0] cand;

  for (genvar k = 0; k < N_REQ; k++) begin : g_cand
    assign cand[k] = ptr + IDX_W'(k);
    assign elig[k] = req[cand[k]] && !(excl_en && (cand[k] == excl_idx));
  end

  // Walk from lowest priority upward so the nearest-to-ptr candidate wins.
  always_comb begin
    any = |elig;
    idx = ptr;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (elig[k]) idx = cand[k];
    end
  end
endmodule

// File: rtl/rr_arbiter_4to2.sv
// 4-way round-robin arbiter with bounded grant hold and registered index output.
// Optional ARB_LOCK_EN adds a lock input that suppresses forced rotation.
module rr_arbiter_4to2
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
`ifdef ARB_LOCK_EN
  input  logic             lock,
`endif
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_vld,
  output logic             gnt_chg
);
  localparam int HW = $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);

  arb_state_t       state_q, state_d;
  logic [IDX_W-1:0] gnt_idx_q, gnt_idx_d;
  logic             gnt_vld_q, gnt_vld_d;
  logic             gnt_chg_q, gnt_chg_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [HW-1:0]    hold_cnt_q, hold_cnt_d;

  logic             lock_w;
  logic             pick_any;
  logic [IDX_W-1:0] pick_idx;
  logic             cur_req;
  logic             in_grant;

`ifdef ARB_LOCK_EN
  assign lock_w = lock;
`else
  assign lock_w = 1'b0;
`endif

  assign in_grant = (state_q == ARB_GRANT);
  assign cur_req  = req[gnt_idx_q];

  rr_pick4 u_pick (
    .req      (req),
    .ptr      (ptr_q),
    .excl_en  (in_grant),
    .excl_idx (gnt_idx_q),
    .any      (pick_any),
    .idx      (pick_idx)
  );

  always_comb begin
    state_d    = state_q;
    gnt_idx_d  = gnt_idx_q;
    gnt_vld_d  = gnt_vld_q;
    gnt_chg_d  = 1'b0;
    ptr_d      = ptr_q;
    hold_cnt_d = hold_cnt_q;

    unique case (state_q)
      ARB_IDLE: begin
        if (pick_any) begin
          state_d    = ARB_GRANT;
          gnt_idx_d  = pick_idx;
          gnt_vld_d  = 1'b1;
          gnt_chg_d  = 1'b1;
          ptr_d      = pick_idx + IDX_W'(1);
          hold_cnt_d = HW'(1);
        end
      end
      ARB_GRANT: begin
        if (!cur_req) begin
          if (pick_any) begin
            gnt_idx_d  = pick_idx;
            gnt_chg_d  = 1'b1;
            ptr_d      = pick_idx + IDX_W'(1);
            hold_cnt_d = HW'(1);
          end else begin
            // Index is held so the decoder select stays stable while disabled.
            state_d    = ARB_IDLE;
            gnt_vld_d  = 1'b0;
            hold_cnt_d = '0;
          end
        end else if ((hold_cnt_q == HOLD_MAX) && pick_any && !lock_w) begin
          gnt_idx_d  = pick_idx;
          gnt_chg_d  = 1'b1;
          ptr_d      = pick_idx + IDX_W'(1);
          hold_cnt_d = HW'(1);
        end else if (hold_cnt_q != HOLD_MAX) begin
          hold_cnt_d = hold_cnt_q + HW'(1);
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ARB_IDLE;
      gnt_idx_q  <= '0;
      gnt_vld_q  <= 1'b0;
      gnt_chg_q  <= 1'b0;
      ptr_q      <= '0;
      hold_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      gnt_idx_q  <= gnt_idx_d;
      gnt_vld_q  <= gnt_vld_d;
      gnt_chg_q  <= gnt_chg_d;
      ptr_q      <= ptr_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  assign gnt_idx = gnt_idx_q;
  assign gnt_vld = gnt_vld_q;
  assign gnt_chg = gnt_chg_q;
endmodule

// File: tb/tb_rr_arbiter_4to2.sv
// Bench for rr_arbiter_4to2: vector table, multi-cycle corner sequences, and
// randomized traffic checked against a rule-level reference model.
module tb_rr_arbiter_4to2;
  localparam int MAXH = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req;
  logic [1:0] gnt_idx;
  logic       gnt_vld;
  logic       gnt_chg;
`ifdef ARB_LOCK_EN
  logic       lock = 1'b0;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  int m_g, m_vld, m_chg, m_cnt, m_p;

  always #5 clk = ~clk;

  rr_arbiter_4to2 #(.MAX_HOLD(MAXH)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
`ifdef ARB_LOCK_EN
    .lock    (lock),
`endif
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld),
    .gnt_chg (gnt_chg)
  );

  typedef struct {
    logic       rst_n;
    logic [3:0] req;
    logic       vld;
    logic [1:0] idx;
    logic       chg;
  } vec_t;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int pick(input logic [3:0] r, input int p, input bit excl, input int cur);
    for (int k = 0; k < 4; k++) begin
      int c;
      c = (p + k) % 4;
      if (r[c] && !(excl && c == cur)) return c;
    end
    return -1;
  endfunction

  task automatic model_edge();
    int w;
    m_chg = 0;
    if (!rst_n) begin
      m_g = 0; m_vld = 0; m_cnt = 0; m_p = 0;
      return;
    end
    if (!m_vld) begin
      w = pick(req, m_p, 1'b0, 0);
    end else if (!req[m_g]) begin
      w = pick(req, m_p, 1'b1, m_g);
      if (w < 0) begin
        m_vld = 0; m_cnt = 0;
      end
    end else begin
      w = (m_cnt == MAXH) ? pick(req, m_p, 1'b1, m_g) : -1;
      if (w < 0 && m_cnt < MAXH) m_cnt++;
    end
    if (w >= 0) begin
      m_g = w; m_vld = 1; m_chg = 1; m_cnt = 1; m_p = (w + 1) % 4;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  vec_t vecs[16];

  initial begin
    rst_n = 1'b0;
    req   = 4'b1111;
    m_g = 0; m_vld = 0; m_chg = 0; m_cnt = 0; m_p = 0;

    // reset, single request, release, then rotation 0,1,2,3,0
    vecs[0]  = '{1'b0, 4'b1111, 1'b0, 2'd0, 1'b0};
    vecs[1]  = '{1'b0, 4'b1111, 1'b0, 2'd0, 1'b0};
    vecs[2]  = '{1'b1, 4'b0100, 1'b1, 2'd2, 1'b1};
    vecs[3]  = '{1'b1, 4'b0100, 1'b1, 2'd2, 1'b0};
    vecs[4]  = '{1'b1, 4'b0000, 1'b0, 2'd2, 1'b0};
    vecs[5]  = '{1'b1, 4'b0000, 1'b0, 2'd2, 1'b0};
    vecs[6]  = '{1'b0, 4'b1111, 1'b0, 2'd0, 1'b0};
    vecs[7]  = '{1'b1, 4'b1111, 1'b1, 2'd0, 1'b1};
    vecs[8]  = '{1'b1, 4'b1111, 1'b1, 2'd0, 1'b0};
    vecs[9]  = '{1'b1, 4'b1110, 1'b1, 2'd1, 1'b1};
    vecs[10] = '{1'b1, 4'b1110, 1'b1, 2'd1, 1'b0};
    vecs[11] = '{1'b1, 4'b1100, 1'b1, 2'd2, 1'b1};
    vecs[12] = '{1'b1, 4'b1100, 1'b1, 2'd2, 1'b0};
    vecs[13] = '{1'b1, 4'b1000, 1'b1, 2'd3, 1'b1};
    vecs[14] = '{1'b1, 4'b1000, 1'b1, 2'd3, 1'b0};
    vecs[15] = '{1'b1, 4'b0111, 1'b1, 2'd0, 1'b1};

    for (int i = 0; i < 16; i++) begin
      rst_n = vecs[i].rst_n;
      req   = vecs[i].req;
      step();
      check($sformatf("vec%0d_vld", i), int'(gnt_vld), int'(vecs[i].vld));
      check($sformatf("vec%0d_idx", i), int'(gnt_idx), int'(vecs[i].idx));
      check($sformatf("vec%0d_chg", i), int'(gnt_chg), int'(vecs[i].chg));
    end

    // Hold limit: two contenders alternate every MAXH cycles
    req = 4'b0011;
    do_reset();
    for (int i = 0; i < 3 * MAXH; i++) begin
      step();
      check($sformatf("hold%0d_idx", i), int'(gnt_idx), (i / MAXH) % 2);
      check($sformatf("hold%0d_chg", i), int'(gnt_chg), int'(i % MAXH == 0));
      check($sformatf("hold%0d_vld", i), int'(gnt_vld), 1);
    end

    // Sole requester keeps the grant, hold counter saturates
    req = 4'b1000;
    do_reset();
    for (int i = 0; i < 20; i++) begin
      step();
      check($sformatf("sole%0d_idx", i), int'(gnt_idx), 3);
      check($sformatf("sole%0d_chg", i), int'(gnt_chg), int'(i == 0));
    end
    check("sole_hold_sat", int'(dut.hold_cnt_q), MAXH);

    // Mid-grant reset, then fresh arbitration starts from index 0
    req = 4'b0010;
    do_reset();
    step();
    step();
    check("mid_pre_idx", int'(gnt_idx), 1);
    rst_n = 1'b0;
    step();
    check("mid_rst_vld", int'(gnt_vld), 0);
    check("mid_rst_idx", int'(gnt_idx), 0);
    check("mid_rst_ptr", int'(dut.ptr_q), 0);
    rst_n = 1'b1;
    req   = 4'b1111;
    step();
    check("mid_post_idx", int'(gnt_idx), 0);
    check("mid_post_chg", int'(gnt_chg), 1);

    // Randomized traffic against the model; requests mostly held as levels
    for (int i = 0; i < 600; i++) begin
      rst_n = ($urandom_range(0, 99) != 0);
      if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
      else if ($urandom_range(0, 2) == 0 && m_vld != 0) req[m_g] = 1'b0;
      step();
      check($sformatf("rnd%0d_vld", i), int'(gnt_vld), m_vld);
      check($sformatf("rnd%0d_idx", i), int'(gnt_idx), m_g);
      check($sformatf("rnd%0d_chg", i), int'(gnt_chg), m_chg);
      check($sformatf("rnd%0d_idx_known", i), int'($isunknown(gnt_idx)), 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
